memory_access: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM latch and the write-back stage. It holds the data memory and performs byte, halfword and word loads and stores with sign or zero extension. It also owns the MEM/WB pipeline register and exposes a debug read port for the debug unit.

---
 rtl/memory_access.sv | 172 +++++++++++++++++
 tb/tb_memory_access.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory-access stage of the five-stage MIPS pipeline: data memory with byte,
// halfword and word loads/stores, the MEM/WB pipeline register and a debug read port.
module memory_access #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_PC   = 32,
    parameter int NB_ADDR = 7
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_flush,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_to_reg,
    input  logic               i_MEM_mem_read,
    input  logic               i_MEM_mem_write,
    input  logic [1:0]         i_MEM_size,
    input  logic               i_MEM_unsigned,
    input  logic [NB_DATA-1:0] i_MEM_alu_result,
    input  logic [NB_DATA-1:0] i_MEM_write_data,
    input  logic [NB_REG-1:0]  i_MEM_selected_reg,
    input  logic [NB_PC-1:0]   i_MEM_pc,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic               o_WB_reg_write,
    output logic               o_WB_mem_to_reg,
    output logic [NB_DATA-1:0] o_WB_mem_data,
    output logic [NB_DATA-1:0] o_WB_alu_result,
    output logic [NB_REG-1:0]  o_WB_selected_reg,
    output logic [NB_PC-1:0]   o_WB_pc,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_debug_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    function automatic logic [NB_DATA-1:0] extend_byte(input logic [7:0] b, input logic uns);
        extend_byte = {{(NB_DATA-8){~uns & b[7]}}, b};
    endfunction

    function automatic logic [NB_DATA-1:0] extend_half(input logic [15:0] h, input logic uns);
        extend_half = {{(NB_DATA-16){~uns & h[15]}}, h};
    endfunction

    logic [NB_DATA-1:0] mem_r [0:DEPTH-1];

    logic [NB_ADDR-1:0] word_idx_s;
    logic [1:0]         lane_s;
    logic               is_half_s;
    logic               is_word_s;
    logic               access_s;
    logic               misaligned_s;
    logic               load_ok_s;
    logic               store_en_s;
    logic [NB_DATA-1:0] rd_word_s;
    logic [NB_DATA-1:0] rd_shift_s;
    logic [NB_DATA-1:0] load_data_s;
    logic [3:0]         byte_en_s;
    logic [NB_DATA-1:0] wr_lanes_s;
    logic [NB_DATA-1:0] merged_s;

    logic               wb_reg_write_r;
    logic               wb_mem_to_reg_r;
    logic [NB_DATA-1:0] wb_mem_data_r;
    logic [NB_DATA-1:0] wb_alu_result_r;
    logic [NB_REG-1:0]  wb_selected_reg_r;
    logic [NB_PC-1:0]   wb_pc_r;
    logic               misaligned_r;

    assign word_idx_s   = i_MEM_alu_result[NB_ADDR+1:2];
    assign lane_s       = i_MEM_alu_result[1:0];
    assign is_half_s    = (i_MEM_size == 2'b01);
    assign is_word_s    = i_MEM_size[1];
    assign access_s     = i_MEM_mem_read | i_MEM_mem_write;
    assign misaligned_s = access_s & ((is_half_s & lane_s[0]) | (is_word_s & (lane_s != 2'b00)));
    // A store wins over a simultaneous load, so the load path only opens for a pure read.
    assign load_ok_s    = i_MEM_mem_read & ~i_MEM_mem_write & ~misaligned_s;
    assign store_en_s   = i_reset & i_step & ~i_flush & i_MEM_mem_write & ~misaligned_s;

    assign rd_word_s    = mem_r[word_idx_s];
    assign rd_shift_s   = rd_word_s >> {lane_s, 3'b000};
    assign o_debug_data = mem_r[i_debug_addr];

    // Load-data selection and sign/zero extension.
    always_comb begin
        load_data_s = {NB_DATA{1'b0}};
        if (load_ok_s) begin
            case (i_MEM_size)
                2'b00:   load_data_s = extend_byte(rd_shift_s[7:0], i_MEM_unsigned);
                2'b01:   load_data_s = extend_half(lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0],
                                                   i_MEM_unsigned);
                default: load_data_s = rd_word_s;
            endcase
        end else begin
            load_data_s = {NB_DATA{1'b0}};
        end
    end

    // Byte enables and replicated store lanes, merged with the current word.
    always_comb begin
        byte_en_s  = 4'b0000;
        wr_lanes_s = i_MEM_write_data;
        merged_s   = rd_word_s;
        case (i_MEM_size)
            2'b00: begin
                byte_en_s  = 4'b0001 << lane_s;
                wr_lanes_s = {4{i_MEM_write_data[7:0]}};
            end
            2'b01: begin
                byte_en_s  = 4'b0011 << lane_s;
                wr_lanes_s = {2{i_MEM_write_data[15:0]}};
            end
            default: begin
                byte_en_s  = 4'b1111;
                wr_lanes_s = i_MEM_write_data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (byte_en_s[i]) begin
                merged_s[8*i +: 8] = wr_lanes_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Data memory write port; the array is deliberately left out of reset.
    always_ff @(posedge i_clock) begin
        if (store_en_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    // MEM/WB pipeline register: holds on stall, loads a bubble on flush.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wb_reg_write_r    <= 1'b0;
            wb_mem_to_reg_r   <= 1'b0;
            wb_mem_data_r     <= {NB_DATA{1'b0}};
            wb_alu_result_r   <= {NB_DATA{1'b0}};
            wb_selected_reg_r <= {NB_REG{1'b0}};
            wb_pc_r           <= {NB_PC{1'b0}};
            misaligned_r      <= 1'b0;
        end else if (i_step) begin
            if (i_flush) begin
                wb_reg_write_r    <= 1'b0;
                wb_mem_to_reg_r   <= 1'b0;
                wb_mem_data_r     <= {NB_DATA{1'b0}};
                wb_alu_result_r   <= {NB_DATA{1'b0}};
                wb_selected_reg_r <= {NB_REG{1'b0}};
                wb_pc_r           <= {NB_PC{1'b0}};
                misaligned_r      <= 1'b0;
            end else begin
                wb_reg_write_r    <= i_MEM_reg_write;
                wb_mem_to_reg_r   <= i_MEM_mem_to_reg;
                wb_mem_data_r     <= load_data_s;
                wb_alu_result_r   <= i_MEM_alu_result;
                wb_selected_reg_r <= i_MEM_selected_reg;
                wb_pc_r           <= i_MEM_pc;
                misaligned_r      <= misaligned_s;
            end
        end
    end

    assign o_WB_reg_write    = wb_reg_write_r;
    assign o_WB_mem_to_reg   = wb_mem_to_reg_r;
    assign o_WB_mem_data     = wb_mem_data_r;
    assign o_WB_alu_result   = wb_alu_result_r;
    assign o_WB_selected_reg = wb_selected_reg_r;
    assign o_WB_pc           = wb_pc_r;
    assign o_misaligned      = misaligned_r;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, random traffic
// against a byte-array reference model, and stall/flush/reset sequences.
module tb_memory_access;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_step;
    logic        i_flush;
    logic        i_MEM_reg_write;
    logic        i_MEM_mem_to_reg;
    logic        i_MEM_mem_read;
    logic        i_MEM_mem_write;
    logic [1:0]  i_MEM_size;
    logic        i_MEM_unsigned;
    logic [31:0] i_MEM_alu_result;
    logic [31:0] i_MEM_write_data;
    logic [4:0]  i_MEM_selected_reg;
    logic [31:0] i_MEM_pc;
    logic [6:0]  i_debug_addr;
    logic        o_WB_reg_write;
    logic        o_WB_mem_to_reg;
    logic [31:0] o_WB_mem_data;
    logic [31:0] o_WB_alu_result;
    logic [4:0]  o_WB_selected_reg;
    logic [31:0] o_WB_pc;
    logic        o_misaligned;
    logic [31:0] o_debug_data;

    memory_access dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
        .i_MEM_reg_write(i_MEM_reg_write), .i_MEM_mem_to_reg(i_MEM_mem_to_reg),
        .i_MEM_mem_read(i_MEM_mem_read), .i_MEM_mem_write(i_MEM_mem_write),
        .i_MEM_size(i_MEM_size), .i_MEM_unsigned(i_MEM_unsigned),
        .i_MEM_alu_result(i_MEM_alu_result), .i_MEM_write_data(i_MEM_write_data),
        .i_MEM_selected_reg(i_MEM_selected_reg), .i_MEM_pc(i_MEM_pc),
        .i_debug_addr(i_debug_addr),
        .o_WB_reg_write(o_WB_reg_write), .o_WB_mem_to_reg(o_WB_mem_to_reg),
        .o_WB_mem_data(o_WB_mem_data), .o_WB_alu_result(o_WB_alu_result),
        .o_WB_selected_reg(o_WB_selected_reg), .o_WB_pc(o_WB_pc),
        .o_misaligned(o_misaligned), .o_debug_data(o_debug_data)
    );

    always #5 i_clock = ~i_clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: 512 bytes, little-endian, plus the expected MEM/WB contents.
    logic [7:0]  mem_m [0:511];
    logic        exp_rw, exp_m2r, exp_mis;
    logic [31:0] exp_data, exp_alu, exp_pc;
    logic [4:0]  exp_sel;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_reg_write"}, o_WB_reg_write, exp_rw);
        check({tag, "_mem_to_reg"}, o_WB_mem_to_reg, exp_m2r);
        check({tag, "_mem_data"}, o_WB_mem_data, exp_data);
        check({tag, "_alu_result"}, o_WB_alu_result, exp_alu);
        check({tag, "_sel_reg"}, o_WB_selected_reg, exp_sel);
        check({tag, "_pc"}, o_WB_pc, exp_pc);
        check({tag, "_misaligned"}, o_misaligned, exp_mis);
    endtask

    task automatic clear_expect();
        exp_rw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
        exp_data = 32'd0; exp_alu = 32'd0; exp_pc = 32'd0; exp_sel = 5'd0;
    endtask

    // One pipeline cycle: drive, predict from the byte model, clock, compare.
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic stp, input logic fl, input logic rw);
        int          n;
        int          a;
        logic        mis;
        logic        m2r;
        logic [4:0]  sel;
        logic [31:0] pc;
        logic [31:0] ld;
        m2r = 1'($urandom);
        sel = 5'($urandom);
        pc  = $urandom;
        i_MEM_mem_read = rd; i_MEM_mem_write = wr; i_MEM_size = sz; i_MEM_unsigned = uns;
        i_MEM_alu_result = addr; i_MEM_write_data = wdata; i_step = stp; i_flush = fl;
        i_MEM_reg_write = rw; i_MEM_mem_to_reg = m2r; i_MEM_selected_reg = sel; i_MEM_pc = pc;
        a   = int'(addr[8:0]);
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (rd || wr) && ((a % n) != 0);
        ld  = 32'd0;
        if (rd && !wr && !mis) begin
            for (int i = 0; i < n; i++) ld = ld | (32'(mem_m[a+i]) << (8*i));
            if (!uns && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8*n));
        end
        @(posedge i_clock);
        if (stp) begin
            if (fl) clear_expect();
            else begin
                exp_rw = rw; exp_m2r = m2r; exp_data = ld; exp_alu = addr;
                exp_sel = sel; exp_pc = pc; exp_mis = mis;
                if (wr && !mis) for (int i = 0; i < n; i++) mem_m[a+i] = wdata[8*i +: 8];
            end
        end
        #1;
        check_outputs("op");
        i_debug_addr = 7'(a >> 2);
        #1;
        check("debug", o_debug_data, model_word(a >> 2));
    endtask

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h55,       32'h0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h1234,     32'h0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h12, 32'h0,        32'h0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h0000DEAD, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h14, 32'h12345678, 32'h0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h16, 32'h0,        32'h00000034, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFFA5A5, 32'h0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h14, 32'h0,        32'hA5A55678, 1'b0};

        i_reset = 1'b0; i_step = 1'b0; i_flush = 1'b0;
        i_MEM_reg_write = 1'b0; i_MEM_mem_to_reg = 1'b0; i_MEM_mem_read = 1'b0;
        i_MEM_mem_write = 1'b0; i_MEM_size = 2'b00; i_MEM_unsigned = 1'b0;
        i_MEM_alu_result = 32'd0; i_MEM_write_data = 32'd0; i_MEM_selected_reg = 5'd0;
        i_MEM_pc = 32'd0; i_debug_addr = 7'd0;
        clear_expect();
        #12;
        check_outputs("reset");
        @(negedge i_clock);
        i_reset = 1'b1;

        // Fill every word so later loads never see uninitialised contents.
        for (int w = 0; w < 128; w++) do_op(1'b0, 1'b1, 2'b11, 1'b0, 32'(w*4), $urandom, 1'b1, 1'b0, 1'b1);

        for (int v = 0; v < 17; v++) begin
            do_op(vecs[v].rd, vecs[v].wr, vecs[v].sz, vecs[v].uns, vecs[v].addr, vecs[v].wdata,
                  1'b1, 1'b0, 1'b1);
            check($sformatf("tbl%0d_data", v), o_WB_mem_data, vecs[v].exp_data);
            check($sformatf("tbl%0d_mis", v), 32'(o_misaligned), 32'(vecs[v].exp_mis));
        end
        i_debug_addr = 7'd4;
        #1;
        check("tbl_debug_word4", o_debug_data, 32'hDEAD55EF);

        // Stall with a store pending, then release it into a flush.
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) do_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
        do_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1);
        check("flush_reg_write", 32'(o_WB_reg_write), 32'd0);
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);

        // Store then immediate load of the same word.
        do_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h44, 32'h600DF00D, 1'b1, 1'b0, 1'b1);
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 1'b1);
        check("raw_data", o_WB_mem_data, 32'h600DF00D);

        // Random traffic against the byte model.
        for (int r = 0; r < 400; r++) begin
            do_op(1'($urandom), 1'($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom),
                  $urandom, $urandom, 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom));
        end

        // Mid-cycle reset with a store in flight.
        do_op(1'b0, 1'b0, 2'b11, 1'b0, $urandom, 32'h0, 1'b1, 1'b0, 1'b1);
        i_MEM_mem_write = 1'b1; i_MEM_size = 2'b11; i_MEM_alu_result = 32'h48;
        i_MEM_write_data = 32'h0BADC0DE; i_step = 1'b1; i_flush = 1'b0;
        #3;
        i_reset = 1'b0;
        #1;
        clear_expect();
        check_outputs("async_reset");
        @(posedge i_clock);
        #1;
        check_outputs("reset_held");
        i_reset = 1'b1;
        i_MEM_mem_write = 1'b0;
        i_debug_addr = 7'd18;
        #1;
        check("reset_mem_kept", o_debug_data, model_word(18));
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
